ones_count_accumulator: RTL and testbench

Sequential stage directly downstream of the three-input expression-level ones counter. It consumes the counter's 2-bit result {y1,y0} (0..3 ones per sample) and accumulates it over a frame of FRAME_LEN valid samples. It reports the frame total and the largest single-sample count through a start/done/ack handshake. It turns the combinational per-sample count into a registered per-frame statistic for the next block.

---
 rtl/ones_count_accumulator.sv | 131 +++++++++++++
 tb/tb_ones_count_accumulator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ones_count_accumulator.sv
// Frame accumulator for the 3-input ones counter: sums {y1,y0} over FRAME_LEN
// valid samples and reports the total and the largest per-sample count.
module ones_count_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 5,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             y0,
    input  logic             y1,
    input  logic             ack,
    output logic [SUM_W-1:0] sum,
    output logic [1:0]       max_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [SUM_W-1:0] SUM_MAX     = {SUM_W{1'b1}};

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [1:0]         max_q, max_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, done_q;
    logic [1:0]         sample_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    // Undersized SUM_W must clamp rather than wrap.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + {{(SUM_W-1){1'b0}}, b};
        if (t[SUM_W]) begin
            return SUM_MAX;
        end else begin
            return t[SUM_W-1:0];
        end
    endfunction

    assign sample_s  = {y1, y0};
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d   = {SUM_W{1'b0}};
                    max_d   = 2'd0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    sum_d = sat_add(sum_q, sample_s);
                    max_d = (sample_s > max_q) ? sample_s : max_q;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == FRAME_LEN_C) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    if (start) begin
                        sum_d   = {SUM_W{1'b0}};
                        max_d   = 2'd0;
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                sum_d   = {SUM_W{1'b0}};
                max_d   = 2'd0;
                cnt_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and status flags; flags follow the next state so they are flop outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= {SUM_W{1'b0}};
            max_q   <= 2'd0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_ACCUM);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign sum     = sum_q;
    assign max_cnt = max_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Bench for ones_count_accumulator: three instances (FRAME_LEN 8, 4, and 4 with
// a 3-bit sum) share one stimulus stream and are checked against a frame model.
module tb_ones_count_accumulator;

    logic clk = 1'b0;
    logic rst, start, in_valid, y0, y1, ack;

    logic [4:0] sum_a, sum_b;
    logic [2:0] sum_c;
    logic [1:0] max_a, max_b, max_c;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

    ones_count_accumulator #(.FRAME_LEN(8), .SUM_W(5), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y0(y0), .y1(y1),
        .ack(ack), .sum(sum_a), .max_cnt(max_a), .busy(busy_a), .done(done_a));

    ones_count_accumulator #(.FRAME_LEN(4), .SUM_W(5), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y0(y0), .y1(y1),
        .ack(ack), .sum(sum_b), .max_cnt(max_b), .busy(busy_b), .done(done_b));

    ones_count_accumulator #(.FRAME_LEN(4), .SUM_W(3), .CNT_W(3)) u_dut_c (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .y0(y0), .y1(y1),
        .ack(ack), .sum(sum_c), .max_cnt(max_c), .busy(busy_c), .done(done_c));

    always #5 clk = ~clk;

    int obs_sum[3], obs_max[3], obs_busy[3], obs_done[3];
    always_comb begin
        obs_sum[0] = int'(sum_a);   obs_sum[1] = int'(sum_b);   obs_sum[2] = int'(sum_c);
        obs_max[0] = int'(max_a);   obs_max[1] = int'(max_b);   obs_max[2] = int'(max_c);
        obs_busy[0] = int'(busy_a); obs_busy[1] = int'(busy_b); obs_busy[2] = int'(busy_c);
        obs_done[0] = int'(done_a); obs_done[1] = int'(done_b); obs_done[2] = int'(done_c);
    end

    // Reference model: 0 idle, 1 collecting, 2 result held
    int fl[3]   = '{8, 4, 4};
    int smax[3] = '{31, 31, 7};
    int m_mode[3], m_cnt[3], m_tot[3], m_max[3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_tot[i] = 0; m_max[i] = 0;
        end
    endtask

    task automatic model_clear(input int i);
        m_cnt[i] = 0; m_tot[i] = 0; m_max[i] = 0; m_mode[i] = 1;
    endtask

    task automatic model_step();
        int v;
        v = int'({y1, y0});
        for (int i = 0; i < 3; i++) begin
            if (m_mode[i] == 0) begin
                if (start) model_clear(i);
            end else if (m_mode[i] == 1) begin
                if (in_valid) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    m_tot[i] = m_tot[i] + v;
                    if (v > m_max[i]) m_max[i] = v;
                    if (m_cnt[i] == fl[i]) m_mode[i] = 2;
                end
            end else begin
                if (ack) begin
                    if (start) model_clear(i);
                    else m_mode[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sum[%0d]", i), obs_sum[i],
                  (m_tot[i] > smax[i]) ? smax[i] : m_tot[i]);
            check($sformatf("max[%0d]", i), obs_max[i], m_max[i]);
            check($sformatf("busy[%0d]", i), obs_busy[i], (m_mode[i] == 1) ? 1 : 0);
            check($sformatf("done[%0d]", i), obs_done[i], (m_mode[i] == 2) ? 1 : 0);
        end
    endtask

    // Called at a negedge: apply inputs, let one rising edge happen, check at the next negedge
    task automatic step(input logic st, input logic iv, input int v, input logic ak);
        start = st; in_valid = iv; ack = ak;
        {y1, y0} = 2'(v);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_sum[%0d]", i), obs_sum[i], 0);
            check($sformatf("rst_max[%0d]", i), obs_max[i], 0);
            check($sformatf("rst_busy[%0d]", i), obs_busy[i], 0);
            check($sformatf("rst_done[%0d]", i), obs_done[i], 0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    task automatic frame4(input int v0, input int v1, input int v2, input int v3);
        step(1'b0, 1'b1, v0, 1'b0);
        step(1'b0, 1'b1, v1, 1'b0);
        step(1'b0, 1'b1, v2, 1'b0);
        step(1'b0, 1'b1, v3, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; y0 = 1'b0; y1 = 1'b0; ack = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Basic frame, held result, then ack
        step(1'b1, 1'b0, 0, 1'b0);
        frame4(1, 2, 0, 3);
        check("basic_done", obs_done[1], 1);
        check("basic_sum", obs_sum[1], 6);
        check("basic_max", obs_max[1], 3);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 1'b0);
        check("hold_sum", obs_sum[1], 6);
        step(1'b0, 1'b0, 0, 1'b1);
        check("ack_done", obs_done[1], 0);
        check("ack_sum", obs_sum[1], 6);

        // Ack while idle has no effect
        step(1'b0, 1'b0, 0, 1'b1);
        check("idle_ack_busy", obs_busy[1], 0);

        // Gapped input with the data lines toggling while invalid
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 2, 1'b0);
            if (k < 3) begin
                check("gap_not_done", obs_done[1], 0);
                step(1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0);
                step(1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0);
            end
        end
        check("gap_sum", obs_sum[1], 8);
        check("gap_done", obs_done[1], 1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Back-to-back: ack together with start
        step(1'b1, 1'b0, 0, 1'b0);
        frame4(1, 2, 0, 3);
        check("b2b_first_sum", obs_sum[1], 6);
        step(1'b1, 1'b0, 0, 1'b1);
        check("b2b_busy", obs_busy[1], 1);
        frame4(1, 1, 1, 1);
        check("b2b_sum", obs_sum[1], 4);
        check("b2b_max", obs_max[1], 1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Reset in the middle of a frame
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        check("mid_sum", obs_sum[1], 5);
        do_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        frame4(0, 0, 0, 1);
        check("after_rst_sum", obs_sum[1], 1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Start held during collection must not restart; then saturation on the 3-bit sum
        do_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b1, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 3, 1'b0);
        check("sat_sum", obs_sum[2], 7);
        check("wide_sum", obs_sum[1], 12);
        check("sat_done", obs_done[2], 1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Full-length frame on the FRAME_LEN=8 instance: done on the 9th edge from start
        do_reset();
        step(1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("len8_not_done", obs_done[0], 0);
            step(1'b0, 1'b1, 3, 1'b0);
        end
        check("len8_done", obs_done[0], 1);
        check("len8_sum", obs_sum[0], 24);
        step(1'b0, 1'b0, 0, 1'b1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
